// File: rtl/stream_fifo_src.sv
// stream_fifo_src: first-word-fall-through valid/ready FIFO with fill level.
// Optional producer stall counter enabled by defining STREAM_FIFO_STALL_CNT_EN.
module stream_fifo_src #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [WIDTH-1:0]         s_data_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [WIDTH-1:0]         m_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              stall_cnt_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  if (WIDTH < 1) begin : g_bad_width
    $error("stream_fifo_src: WIDTH must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo_src: DEPTH must be a power of two >= 2");
  end
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic             s_ready_q, push, pop;
  logic [WIDTH-1:0] data_q;
  assign m_valid_o = wr_q != rd_q;
  assign s_ready_o = s_ready_q;
  assign push      = s_valid_i && s_ready_q;
  assign pop       = m_valid_o && m_ready_i;
  assign wr_d      = wr_q + PW'(push);
  assign rd_d      = rd_q + PW'(pop);
  assign level_o   = wr_q - rd_q;
  // data_q remembers the last presented head so m_data_o holds once drained
  assign m_data_o  = m_valid_o ? mem_q[rd_q[AW-1:0]] : data_q;
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= s_data_i;
  end
  // ready is computed from next-state pointers so it never depends on m_ready_i combinationally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q      <= '0;
      rd_q      <= '0;
      s_ready_q <= 1'b1;
      data_q    <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      s_ready_q <= !((wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]));
      data_q    <= m_data_o;
    end
  end
`ifdef STREAM_FIFO_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else if (s_valid_i && !s_ready_q && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_stream_fifo_src.sv
// tb_stream_fifo_src: randomized self-checking bench for stream_fifo_src against a queue model.
module tb_stream_fifo_src;
  localparam int DEPTH = 4;
`ifdef STREAM_FIFO_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] s_data_i = 8'h00;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [7:0] m_data_o;
  logic [2:0] level_o;
  logic [15:0] stall_cnt_o;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] last_out = 8'h00;
  logic [15:0] stall_exp = 16'h0000;

  stream_fifo_src #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .level_o(level_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    bit push, pop;
    push = s_valid_i && (q.size() < DEPTH);
    pop  = m_ready_i && (q.size() > 0);
    if (STALL_EN && s_valid_i && q.size() == DEPTH && stall_exp != 16'hFFFF) stall_exp++;
    @(posedge clk_i);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(s_data_i);
    #1;
    if (q.size() > 0) last_out = q[0];
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    checks++; if (level_o !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid_o); end
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", s_ready_o); end
    checks++; if (m_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", m_data_o); end
    checks++; if (stall_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_stall got=%h exp=0000", stall_cnt_o); end
    s_valid_i = 1'b1; s_data_i = 8'hA5;
    step();
    s_valid_i = 1'b0;
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'hA5 || level_o !== 3'd1)
      begin failures++; $display("FAIL single_word got v=%b d=%h l=%0d exp v=1 d=a5 l=1", m_valid_o, m_data_o, level_o); end
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0 || m_data_o !== 8'hA5 || level_o !== 3'd0)
      begin failures++; $display("FAIL drain_hold got v=%b d=%h l=%0d exp v=0 d=a5 l=0", m_valid_o, m_data_o, level_o); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'(i);
      step();
      checks++; if (level_o !== 3'(i)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", level_o, i); end
    end
    checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", s_ready_o); end
    s_data_i = 8'h05;
    repeat (3) step();
    s_valid_i = 1'b0;
    checks++; if (level_o !== 3'd4) begin failures++; $display("FAIL full_hold_level got=%0d exp=4", level_o); end
    checks++; if (stall_cnt_o !== (STALL_EN ? 16'd3 : 16'd0))
      begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt_o, STALL_EN ? 3 : 0); end
    checks++; if (stall_cnt_o !== stall_exp) begin failures++; $display("FAIL stall_model got=%0d exp=%0d", stall_cnt_o, stall_exp); end
    m_ready_i = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'(i))
        begin failures++; $display("FAIL fill_order got v=%b d=%h exp v=1 d=%h", m_valid_o, m_data_o, 8'(i)); end
      step();
    end
    m_ready_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0 || level_o !== 3'd0)
      begin failures++; $display("FAIL fill_drained got v=%b l=%0d exp v=0 l=0", m_valid_o, level_o); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'($urandom_range(0, 8'h98));
      step();
    end
    m_ready_i = 1'b1; s_data_i = 8'h99;
    step();
    s_valid_i = 1'b0; m_ready_i = 1'b0;
    checks++; if (level_o !== 3'd3) begin failures++; $display("FAIL full_pop_level got=%0d exp=3", level_o); end
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", s_ready_o); end
    m_ready_i = 1'b1;
    while (q.size() > 0) begin
      checks++; if (m_valid_o !== 1'b1 || m_data_o !== q[0] || m_data_o === 8'h99)
        begin failures++; $display("FAIL full_pop_data got v=%b d=%h exp v=1 d=%h", m_valid_o, m_data_o, q[0]); end
      step();
    end
    m_ready_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL full_pop_empty got=%b exp=0", m_valid_o); end
  endtask

  task automatic test_streaming();
    logic [7:0] base;
    base = 8'($urandom);
    s_valid_i = 1'b1; m_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_data_i = base + 8'(k);
      step();
      checks++; if (level_o !== 3'd1 || m_valid_o !== 1'b1 || m_data_o !== base + 8'(k))
        begin failures++; $display("FAIL stream k=%0d got l=%0d v=%b d=%h exp l=1 v=1 d=%h", k, level_o, m_valid_o, m_data_o, base + 8'(k)); end
    end
    s_valid_i = 1'b0;
    step();
    m_ready_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0 || level_o !== 3'd0)
      begin failures++; $display("FAIL stream_end got v=%b l=%0d exp v=0 l=0", m_valid_o, level_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    int rx, tx, guard;
    rx = 0; tx = 0; guard = 0;
    while (rx < 3 * DEPTH && guard < 600) begin
      s_valid_i = (tx < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      s_data_i = 8'($urandom);
      m_ready_i = $urandom_range(0, 2) != 0;
      if (s_valid_i && s_ready_o) begin sent.push_back(s_data_i); tx++; end
      if (m_valid_o && m_ready_i) begin
        checks++; if (m_data_o !== sent[rx]) begin failures++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", rx, m_data_o, sent[rx]); end
        rx++;
      end
      step();
      guard++;
      if (m_valid_o !== (q.size() > 0) || level_o !== 3'(q.size()) || s_ready_o !== (q.size() < DEPTH)) begin
        checks++; failures++;
        $display("FAIL wrap_state got v=%b l=%0d r=%b exp l=%0d", m_valid_o, level_o, s_ready_o, q.size());
      end
    end
    s_valid_i = 1'b0; m_ready_i = 1'b0;
    checks++; if (rx != 3 * DEPTH || tx != 3 * DEPTH)
      begin failures++; $display("FAIL wrap_count got rx=%0d tx=%0d exp=%0d", rx, tx, 3 * DEPTH); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'($urandom);
      step();
    end
    s_valid_i = 1'b0;
    checks++; if (level_o !== 3'd3) begin failures++; $display("FAIL pre_reset_level got=%0d exp=3", level_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (m_valid_o !== 1'b0 || level_o !== 3'd0 || s_ready_o !== 1'b1)
      begin failures++; $display("FAIL async_reset got v=%b l=%0d r=%b exp v=0 l=0 r=1", m_valid_o, level_o, s_ready_o); end
    q.delete(); last_out = 8'h00; stall_exp = 16'h0;
    #2 rst_ni = 1'b1;
    step();
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_stale got=%b exp=0", m_valid_o); end
    s_valid_i = 1'b1; s_data_i = 8'h3C;
    step();
    s_valid_i = 1'b0;
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h3C || level_o !== 3'd1)
      begin failures++; $display("FAIL post_reset_push got v=%b d=%h l=%0d exp v=1 d=3c l=1", m_valid_o, m_data_o, level_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_streaming();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_fifo_src.md
Name: stream_fifo_src

Overview:
- Small first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the datapath stage: absorbs bursty producer traffic and presents one word at a time on m_data_o, which drives that stage's data_i.
- Decouples producer backpressure from the consumer; reports fill level for flow-control logic.

Parameters:
- WIDTH, 8, data word width in bits; 0 is illegal and must raise an elaboration error.
- DEPTH, 4, number of storage entries; power of two, >= 2; other values must raise an elaboration error.

Ports:
- clk_i  input  1  sole clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset; assertion clears all state immediately; deassertion is synchronised externally.
- s_valid_i  input  1  producer has a word on s_data_i.
- s_ready_o  output  1  FIFO can accept a word this cycle.
- s_data_i  input  WIDTH  producer data.
- m_valid_o  output  1  m_data_o holds the oldest stored word.
- m_ready_i  input  1  consumer takes the word this cycle.
- m_data_o  output  WIDTH  head-of-queue data; feeds downstream data_i.
- level_o  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- stall_cnt_o  output  16  producer stall counter (see Optional Feature).

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Read and write pointers = 0; level_o = 0.
  - m_valid_o = 0; m_data_o = 0; s_ready_o = 1 once the reset condition is cleared.
  - Storage contents need not be cleared.
- Push: s_valid_i && s_ready_o at a rising edge writes s_data_i at wr_ptr; wr_ptr increments.
- Pop: m_valid_o && m_ready_i at a rising edge discards the head; rd_ptr increments.
- Pointers:
  - Each pointer is $clog2(DEPTH)+1 bits and wraps naturally at 2*DEPTH.
  - Address = low $clog2(DEPTH) bits.
  - full = (MSBs differ) && (address bits equal); empty = (pointers equal).
- s_ready_o = !full, registered so that it changes only on clock edges. No combinational path from m_ready_i to s_ready_o.
  - Consequence: a pop in the same cycle the FIFO is full does not allow a simultaneous push. s_ready_o rises one cycle after the pop.
- m_valid_o = !empty. m_data_o = mem[rd_addr] when m_valid_o = 1, otherwise holds its last value (0 after reset).
- Latency:
  - A word pushed at edge N is visible on m_valid_o/m_data_o after edge N.
  - It is poppable at edge N+1.
  - No pass-through when empty.
- Simultaneous push and pop (neither full nor empty): both pointers advance and level_o is unchanged.
- level_o = wr_ptr - rd_ptr, modulo 2*DEPTH, in pointer width.
- Handshake rules:
  - s_data_i is sampled only on an accepted push.
  - Producer may drop s_valid_i without penalty.
  - m_valid_o never deasserts without a pop, and m_data_o is stable while m_valid_o && !m_ready_i.
- Ignored requests: push while full and pop while empty are impossible by handshake; the FIFO ignores them and must not corrupt pointers.
- Reset mid-operation: contents are discarded; no stale word may appear on m_valid_o after reset release.

Optional Feature:
- Macro: STREAM_FIFO_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments on each clock edge where s_valid_i = 1 and s_ready_o = 0.
  - Saturates at 16'hFFFF; cleared only by rst_ni.
- Not defined: stall_cnt_o is tied to 16'h0000 and no counter register exists.

Test Plan:
1. Reset then single word: after reset, check level_o = 0, m_valid_o = 0, s_ready_o = 1. Push 8'hA5 with m_ready_i = 0 → next cycle m_valid_o = 1, m_data_o = 8'hA5, level_o = 1.
2. Fill to full (DEPTH = 4): push 8'h01..8'h04 with m_ready_i = 0 → level_o = 4, s_ready_o = 0. Holding s_valid_i with 8'h05 for 3 cycles is not accepted; with STREAM_FIFO_STALL_CNT_EN, stall_cnt_o = 3. Then pop all → order is 01, 02, 03, 04.
3. Full plus pop: FIFO full, assert m_ready_i and s_valid_i (8'h99) in the same cycle → head popped, 8'h99 not written. s_ready_o = 1 the next cycle; level_o = 3.
4. Streaming: s_valid_i = m_ready_i = 1 continuously with an incrementing counter for 20 cycles → after a 1-cycle fill, output matches the input sequence in order and level_o stays at 1.
5. Pointer wrap: 3 × DEPTH push/pop pairs with random backpressure → no loss or duplication; scoreboard matches all 12 words.
6. Async reset mid-burst: with level_o = 3, pulse rst_ni low between clock edges → m_valid_o = 0 and level_o = 0 immediately, without waiting for a clock. The first post-reset push of 8'h3C is the next word out.
